// File: rtl/ram_1p_arb_if.sv
// Requester-side bundle of ram_1p_arb: two req/gnt/rvalid ports.
// The arbiter is the slave; the fetch and data ports are the master.
interface ram_1p_arb_if #(
    parameter int Width = 32,
    parameter int Depth = 128
);
    localparam int Aw = $clog2(Depth);

    logic [1:0]                req_i;
    logic [1:0]                we_i;
    logic [1:0][Width/8-1:0]   be_i;
    logic [1:0][Aw-1:0]        addr_i;
    logic [1:0][Width-1:0]     wdata_i;
    logic [1:0]                gnt_o;
    logic [1:0]                rvalid_o;
    logic [1:0][Width-1:0]     rdata_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/ram_1p_arb.sv
// ram_1p_arb: round-robin two-requester arbiter in front of one single-port RAM.
// Define RAM_ARB_RMW_EN to emulate partial writes by read-modify-write.
module ram_1p_arb #(
    parameter  int Width = 32,
    parameter  int Depth = 128,
    localparam int Aw    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    ram_1p_arb_if.slave      bus,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);
    localparam int Bw = Width / 8;

    logic             prio_q;
    logic             rsp_vld_q;
    logic             rsp_vld_d;
    logic             rsp_own_q;
    logic             rsp_own_d;
    logic             accept;
    logic [1:0]       cand;
    logic             any;
    logic             win;
    logic [Bw-1:0]    be_w;
    logic [Width-1:0] mask_w;

`ifdef RAM_ARB_RMW_EN
    typedef enum logic {IDLE, RMW_WR} state_e;

    state_e           state_q;
    state_e           state_d;
    logic             part_w;
    logic [Aw-1:0]    addr_q;
    logic [Width-1:0] wdata_q;
    logic [Bw-1:0]    be_q;
    logic [Width-1:0] merged;

    assign accept = rst_ni && (state_q == IDLE);
    assign part_w = bus.we_i[win] && (be_w != '1) && (be_w != '0);
`else
    assign accept = rst_ni;
`endif

    // Reset gates the request path so nothing is granted while held in reset.
    assign cand = bus.req_i & {2{accept}};
    assign any  = |cand;
    assign win  = (&cand) ? prio_q : cand[1];

    always_comb begin
        be_w   = bus.be_i[win];
        mask_w = '0;
        for (int i = 0; i < Bw; i++) begin
            mask_w[i*8 +: 8] = {8{be_w[i]}};
        end
    end

    always_comb begin
        bus.gnt_o = '0;
        if (any) begin
            bus.gnt_o[win] = 1'b1;
        end
    end

    always_comb begin
        bus.rvalid_o = '0;
        if (rsp_vld_q) begin
            bus.rvalid_o[rsp_own_q] = 1'b1;
        end
    end

    assign bus.rdata_o = {2{ram_rdata_i}};

`ifdef RAM_ARB_RMW_EN
    always_comb begin
        merged = '0;
        for (int i = 0; i < Bw; i++) begin
            merged[i*8 +: 8] = be_q[i] ? wdata_q[i*8 +: 8]
                                       : ram_rdata_i[i*8 +: 8];
        end
    end
`endif

    always_comb begin
        ram_req_o   = any;
        ram_write_o = any & bus.we_i[win];
        ram_addr_o  = bus.addr_i[win];
        ram_wdata_o = bus.wdata_i[win];
        ram_wmask_o = ram_write_o ? mask_w : '0;
        rsp_vld_d   = any;
        rsp_own_d   = any ? win : rsp_own_q;
`ifdef RAM_ARB_RMW_EN
        state_d = state_q;
        unique case (1'b1)
            (state_q == RMW_WR): begin
                ram_req_o   = 1'b1;
                ram_write_o = 1'b1;
                ram_addr_o  = addr_q;
                ram_wdata_o = merged;
                ram_wmask_o = '1;
                rsp_vld_d   = 1'b1;
                state_d     = IDLE;
            end
            (any && part_w): begin
                // First half of RMW: read the old word, write it back next cycle.
                ram_write_o = 1'b0;
                ram_wmask_o = '0;
                rsp_vld_d   = 1'b0;
                state_d     = RMW_WR;
            end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= 1'b0;
            rsp_vld_q <= 1'b0;
            rsp_own_q <= 1'b0;
        end else begin
            if (any) begin
                prio_q <= ~win;
            end
            rsp_vld_q <= rsp_vld_d;
            rsp_own_q <= rsp_own_d;
        end
    end

`ifdef RAM_ARB_RMW_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (any && part_w) begin
                addr_q  <= bus.addr_i[win];
                wdata_q <= bus.wdata_i[win];
                be_q    <= be_w;
            end
        end
    end
`endif
endmodule

// File: tb/tb_ram_1p_arb.sv
// Bench for ram_1p_arb: directed and random traffic against a reference model.
// Responses are predicted at grant time and checked by a separate monitor.
module tb_ram_1p_arb;
    localparam int W  = 32;
    localparam int D  = 128;
    localparam int AW = 7;
    localparam int BW = 4;

    typedef struct {
        bit            idle;
        bit            we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
    } txn_t;

    typedef struct {
        bit           own;
        bit           rd;
        logic [W-1:0] data;
        int           due;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_req;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_wmask;
    logic [W-1:0]  ram_rdata = '0;

    always #5 clk = ~clk;

    ram_1p_arb_if #(.Width(W), .Depth(D)) bus ();

    ram_1p_arb #(.Width(W), .Depth(D)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .ram_req_o   (ram_req),
        .ram_write_o (ram_write),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wmask_o (ram_wmask),
        .ram_rdata_i (ram_rdata)
    );

    function automatic logic [W-1:0] init_val(int i);
        return 32'h5A00_0000 ^ (i * 32'h0001_0203);
    endfunction

    function automatic logic [W-1:0] expand(logic [BW-1:0] be);
        logic [W-1:0] m;
        for (int i = 0; i < BW; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic logic [W-1:0] merge(logic [W-1:0] old,
                                           logic [W-1:0] nw,
                                           logic [BW-1:0] be);
        logic [W-1:0] m;
        m = expand(be);
        return (old & ~m) | (nw & m);
    endfunction

    // Physical RAM attached to the DUT
    logic [W-1:0] mem [D];
    bit           init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < D; i++) mem[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (ram_req) begin
            if (ram_write)
                mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            else
                ram_rdata <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input bit ok, input string nm,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model state
    logic [W-1:0] ref_mem [D];
    txn_t         tq0[$];
    txn_t         tq1[$];
    txn_t         cur[2];
    bit           cur_v[2];
    bit           granted[2];
    bit           prio_m;
    bit           busy_m;
    logic [AW-1:0] pend_a;
    logic [W-1:0] pend_d;
    rsp_t         sb[$];
    bit           rst_cmd;

    function automatic txn_t mk(bit idle, bit we, logic [BW-1:0] be,
                                logic [AW-1:0] a, logic [W-1:0] d);
        txn_t t;
        t.idle = idle; t.we = we; t.be = be; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        int   k;
        t.idle  = ($urandom_range(0, 3) == 0);
        t.we    = 1'($urandom_range(0, 1));
        k       = $urandom_range(0, 3);
        t.be    = (k == 0) ? 4'hF : (k == 1) ? 4'h0 : 4'($urandom);
        t.addr  = 7'($urandom_range(0, 15));
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic drive();
        @(posedge clk);
        #1;
        rst_n = rst_cmd;
        for (int r = 0; r < 2; r++) begin
            if (cur_v[r] && granted[r]) cur_v[r] = 1'b0;
            if (!cur_v[r]) begin
                txn_t t;
                bit   have;
                have = (r == 0) ? (tq0.size() > 0) : (tq1.size() > 0);
                if (have) begin
                    t = (r == 0) ? tq0.pop_front() : tq1.pop_front();
                    if (!t.idle) begin
                        cur[r]   = t;
                        cur_v[r] = 1'b1;
                    end
                end
            end
            bus.req_i[r]   = cur_v[r];
            bus.we_i[r]    = cur[r].we;
            bus.be_i[r]    = cur[r].be;
            bus.addr_i[r]  = cur[r].addr;
            bus.wdata_i[r] = cur[r].wdata;
        end
    endtask

    task automatic model();
        logic [1:0]   eg;
        logic [1:0]   cand;
        bit           w;
        bit           part;
        txn_t         t;
        logic [72:0]  act;
        logic [72:0]  exp;
        @(negedge clk);
        granted[0] = 1'b0;
        granted[1] = 1'b0;
        act = {ram_req, ram_write, ram_addr, ram_wmask, ram_write ? ram_wdata : 32'h0};
        if (!rst_n) begin
            prio_m = 1'b0;
            busy_m = 1'b0;
            check(bus.gnt_o == 2'b00 && !ram_req, "reset_quiet",
                  {bus.gnt_o, ram_req}, 3'b000);
            return;
        end
        if (busy_m) begin
            exp = {1'b1, 1'b1, pend_a, 32'hFFFF_FFFF, pend_d};
            check(bus.gnt_o == 2'b00 && act == exp, "rmw_write",
                  {bus.gnt_o, act}, {2'b00, exp});
            ref_mem[pend_a] = pend_d;
            busy_m = 1'b0;
            return;
        end
        cand = {cur_v[1], cur_v[0]};
        if (cand == 2'b11) eg = prio_m ? 2'b10 : 2'b01;
        else eg = cand;
        check(bus.gnt_o == eg, "gnt", bus.gnt_o, eg);
        if (eg == 2'b00) begin
            check(!ram_req, "idle_no_strobe", ram_req, 1'b0);
            return;
        end
        w = eg[1];
        t = cur[w];
        granted[w] = 1'b1;
        prio_m = !w;
`ifdef RAM_ARB_RMW_EN
        part = t.we && t.be != 4'hF && t.be != 4'h0;
`else
        part = 1'b0;
`endif
        if (!t.we || part) exp = {1'b1, 1'b0, t.addr, 32'h0, 32'h0};
        else exp = {1'b1, 1'b1, t.addr, expand(t.be), t.wdata};
        check(act == exp, "ram_drive", act, exp);
        if (!t.we) begin
            sb.push_back('{w, 1'b1, ref_mem[t.addr], cyc + 1});
        end else if (part) begin
            pend_a = t.addr;
            pend_d = merge(ref_mem[t.addr], t.wdata, t.be);
            busy_m = 1'b1;
            sb.push_back('{w, 1'b0, 32'h0, cyc + 2});
        end else begin
            ref_mem[t.addr] = merge(ref_mem[t.addr], t.wdata, t.be);
            sb.push_back('{w, 1'b0, 32'h0, cyc + 1});
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            check(bus.rvalid_o == 2'b00, "reset_rvalid", bus.rvalid_o, 2'b00);
            sb.delete();
        end else if (bus.rvalid_o != 2'b00) begin
            if (sb.size() == 0) begin
                check(1'b0, "spurious_rvalid", bus.rvalid_o, 2'b00);
            end else begin
                e = sb.pop_front();
                check(bus.rvalid_o == (e.own ? 2'b10 : 2'b01) && e.due == cyc,
                      "rvalid", {bus.rvalid_o, 32'(cyc)}, {(e.own ? 2'b10 : 2'b01), 32'(e.due)});
                if (e.rd)
                    check(bus.rdata_o[e.own] == e.data, "rdata",
                          bus.rdata_o[e.own], e.data);
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check(1'b0, "missing_rvalid", 32'(cyc), 32'(e.due));
        end
    end

    task automatic cycle();
        drive();
        model();
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((tq0.size() > 0 || tq1.size() > 0 || cur_v[0] || cur_v[1] ||
                sb.size() > 0 || busy_m) && n < lim) begin
            cycle();
            n++;
        end
        if (n >= lim) check(1'b0, "drain_timeout", 32'(n), 32'(lim));
    endtask

    initial begin
        int n;
        for (int i = 0; i < D; i++) ref_mem[i] = init_val(i);
        for (int r = 0; r < 2; r++) begin
            cur[r]     = mk(1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
            cur_v[r]   = 1'b0;
            granted[r] = 1'b0;
        end
        prio_m      = 1'b0;
        busy_m      = 1'b0;
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.be_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        rst_cmd     = 1'b0;

        // Both ports read continuously, held in reset first
        repeat (8) begin
            tq0.push_back(mk(1'b0, 1'b0, 4'h0, 7'h10, 32'h0));
            tq1.push_back(mk(1'b0, 1'b0, 4'h0, 7'h20, 32'h0));
        end
        repeat (3) cycle();
        rst_cmd = 1'b1;
        drain(100);

        // Full write then readback
        tq1.push_back(mk(1'b0, 1'b1, 4'hF, 7'h05, 32'hDEAD_BEEF));
        tq1.push_back(mk(1'b0, 1'b0, 4'h0, 7'h05, 32'h0));
        drain(100);
        check(mem[5] == 32'hDEAD_BEEF, "full_write", mem[5], 32'hDEAD_BEEF);

        // Partial write with be=0101
        tq1.push_back(mk(1'b0, 1'b1, 4'hF, 7'h05, 32'h1122_3344));
        tq1.push_back(mk(1'b0, 1'b1, 4'h5, 7'h05, 32'hAABB_CCDD));
        tq1.push_back(mk(1'b0, 1'b0, 4'h0, 7'h05, 32'h0));
        drain(100);
        check(mem[5] == 32'h11BB_33DD, "partial_write", mem[5], 32'h11BB_33DD);

`ifdef RAM_ARB_RMW_EN
        // Reset during the write-back cycle abandons the RMW
        tq1.push_back(mk(1'b0, 1'b1, 4'hF, 7'h05, 32'h1122_3344));
        drain(100);
        tq1.push_back(mk(1'b0, 1'b1, 4'h5, 7'h05, 32'hAABB_CCDD));
        n = 0;
        while (!granted[1] && n < 50) begin
            cycle();
            n++;
        end
        if (n >= 50) check(1'b0, "rmw_grant_timeout", 32'(n), 32'd50);
        rst_cmd = 1'b0;
        repeat (2) cycle();
        rst_cmd = 1'b1;
        cycle();
        check(mem[5] == 32'h1122_3344, "rmw_reset_abandon", mem[5], 32'h1122_3344);
        tq1.push_back(mk(1'b0, 1'b0, 4'h0, 7'h05, 32'h0));
        drain(100);
`endif

        // Random mixed traffic
        repeat (300) begin
            tq0.push_back(rnd_txn());
            tq1.push_back(rnd_txn());
        end
        drain(5000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
